// File: rtl/clock_gen_pkg.sv
// Shared constants, state encoding and divisor helper for the multi-channel clock generator.
package clock_gen_pkg;

  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned MIN_DIV    = 2;
  localparam int unsigned GAP_W      = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_EXT   = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_GAP   = 2'd2;
  localparam state_t ST_PLL   = 2'd3;

  // Effective divisor: 0 and 1 behave as the minimum divisor.
  function automatic int unsigned neff(input int unsigned n);
    return (n < MIN_DIV) ? MIN_DIV : n;
  endfunction

endpackage

// File: rtl/clock_gen_ch.sv
// One output channel: divide counter, divisor register, req/ack handshake and drain freeze flag.
module clock_gen_ch
  import clock_gen_pkg::*;
#(
  parameter int unsigned DIVW     = 4,
  parameter int unsigned DIV_INIT = 2
) (
  input  logic            pll_clk,
  input  logic            resetb,
  input  state_t          state,
  input  logic            from_ext,
  input  logic            ext_sync,
  input  logic [DIVW-1:0] div_n,
  input  logic            div_req,
  output logic            div_ack,
  output logic            clk_out,
  output logic            frozen
);

  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] neff_v;
  logic [DIVW-1:0] half_v;
  logic            high_v;
  logic            wrap_v;
  logic            load_v;

  // Period decode; PLL-mode loads wait for the wrap so a period is never cut short.
  always_comb begin
    neff_v = DIVW'(neff(32'(div_q)));
    half_v = DIVW'((32'(neff_v) + 32'd1) >> 1);
    high_v = (cnt_q < half_v);
    wrap_v = (cnt_q == (neff_v - DIVW'(1)));
    load_v = div_req & ~div_ack & ((state != ST_PLL) | wrap_v);
  end

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q   <= '0;
      div_q   <= DIVW'(DIV_INIT);
      div_ack <= 1'b0;
      clk_out <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      case (state)
        ST_EXT: begin
          clk_out <= ext_sync;
          cnt_q   <= '0;
          frozen  <= 1'b0;
        end
        ST_DRAIN: begin
          // Freeze only where the output would be low anyway, so no runt is produced.
          if (frozen) begin
            clk_out <= 1'b0;
          end else if (from_ext) begin
            clk_out <= ext_sync;
            frozen  <= ~ext_sync;
          end else if (high_v) begin
            clk_out <= 1'b1;
            cnt_q   <= cnt_q + DIVW'(1);
          end else begin
            clk_out <= 1'b0;
            frozen  <= 1'b1;
          end
        end
        ST_GAP: begin
          clk_out <= 1'b0;
          cnt_q   <= '0;
          frozen  <= 1'b0;
        end
        default: begin
          clk_out <= high_v;
          cnt_q   <= wrap_v ? '0 : cnt_q + DIVW'(1);
          frozen  <= 1'b0;
        end
      endcase

      if (load_v) begin
        div_q   <= div_n;
        div_ack <= 1'b1;
      end else if (!div_req) begin
        div_ack <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/caravel_clock_gen.sv
// Multi-channel clock generator: PLL/ext source FSM with glitch-free switching,
// input synchronisers, staged reset and NCH divider channels.
module caravel_clock_gen
  import clock_gen_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned DIVW        = 4,
  parameter int unsigned DIV_INIT    = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_STAGES  = 3
) (
  input  logic                pll_clk,
  input  logic                resetb,
  input  logic                ext_clk,
  input  logic                ext_clk_sel,
  input  logic                ext_reset,
  input  logic [NCH*DIVW-1:0] div_n,
  input  logic [NCH-1:0]      div_req,
  output logic [NCH-1:0]      div_ack,
  output logic [NCH-1:0]      clk_out,
  output logic                src_pll,
  output logic                switching,
  output logic                resetb_sync
);

  logic [SYNC_STAGES-1:0] ext_sr;
  logic [SYNC_STAGES-1:0] sel_sr;
  logic [RST_STAGES-1:0]  rst_sr;
  logic                   ext_sync;
  logic                   sel_sync;

  state_t                 state_q;
  state_t                 state_nxt;
  logic                   from_ext_q;
  logic                   from_ext_nxt;
  logic [GAP_W-1:0]       gap_q;
  logic [GAP_W-1:0]       gap_nxt;
  logic                   src_pll_nxt;
  logic                   switching_nxt;
  logic [NCH-1:0]         frozen;

  assign ext_sync    = ext_sr[SYNC_STAGES-1];
  assign sel_sync    = sel_sr[SYNC_STAGES-1];
  assign resetb_sync = ~(rst_sr[0] | ext_reset);

  // Select chain resets to "ext" so it agrees with the reset state and no switch fires on release.
  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      ext_sr <= '0;
      sel_sr <= '1;
      rst_sr <= '1;
    end else begin
      ext_sr <= {ext_sr[SYNC_STAGES-2:0], ext_clk};
      sel_sr <= {sel_sr[SYNC_STAGES-2:0], ext_clk_sel};
      rst_sr <= rst_sr >> 1;
    end
  end

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_EXT;
      from_ext_q <= 1'b0;
      gap_q      <= '0;
      src_pll    <= 1'b0;
      switching  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      from_ext_q <= from_ext_nxt;
      gap_q      <= gap_nxt;
      src_pll    <= src_pll_nxt;
      switching  <= switching_nxt;
    end
  end

  // Source FSM; a switch always runs to completion before sel is looked at again.
  always_comb begin
    state_nxt    = state_q;
    from_ext_nxt = from_ext_q;
    gap_nxt      = gap_q;
    case (state_q)
      ST_EXT: begin
        if (!sel_sync) begin
          state_nxt    = ST_DRAIN;
          from_ext_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (&frozen) begin
          state_nxt = ST_GAP;
          gap_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt = from_ext_q ? ST_PLL : ST_EXT;
        end else begin
          gap_nxt = gap_q + GAP_W'(1);
        end
      end
      default: begin
        if (sel_sync) begin
          state_nxt    = ST_DRAIN;
          from_ext_nxt = 1'b0;
        end
      end
    endcase
    src_pll_nxt   = (state_nxt == ST_PLL);
    switching_nxt = (state_nxt == ST_DRAIN) | (state_nxt == ST_GAP);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clock_gen_ch #(
      .DIVW     (DIVW),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .pll_clk  (pll_clk),
      .resetb   (resetb),
      .state    (state_q),
      .from_ext (from_ext_q),
      .ext_sync (ext_sync),
      .div_n    (div_n[i*DIVW +: DIVW]),
      .div_req  (div_req[i]),
      .div_ack  (div_ack[i]),
      .clk_out  (clk_out[i]),
      .frozen   (frozen[i])
    );
  end

endmodule

// File: tb/tb_caravel_clock_gen.sv
// Bench for caravel_clock_gen: cycle-level behavioural model with a per-cycle compare,
// plus directed scenarios with hand-computed expectations.
module tb_caravel_clock_gen;

  localparam int NCH  = 2;
  localparam int DIVW = 4;
  localparam int DINI = 2;
  localparam int SYNC = 2;
  localparam int RSTS = 3;

  logic                pll_clk;
  logic                resetb;
  logic                ext_clk;
  logic                ext_clk_sel;
  logic                ext_reset;
  logic [NCH*DIVW-1:0] div_n;
  logic [NCH-1:0]      div_req;
  logic [NCH-1:0]      div_ack;
  logic [NCH-1:0]      clk_out;
  logic                src_pll;
  logic                switching;
  logic                resetb_sync;

  caravel_clock_gen #(
    .NCH(NCH), .DIVW(DIVW), .DIV_INIT(DINI), .SYNC_STAGES(SYNC), .RST_STAGES(RSTS)
  ) dut (
    .pll_clk(pll_clk), .resetb(resetb), .ext_clk(ext_clk), .ext_clk_sel(ext_clk_sel),
    .ext_reset(ext_reset), .div_n(div_n), .div_req(div_req), .div_ack(div_ack),
    .clk_out(clk_out), .src_pll(src_pll), .switching(switching), .resetb_sync(resetb_sync)
  );

  initial pll_clk = 1'b0;
  always #5 pll_clk = ~pll_clk;

  // Pad clock: 10 pll_clk periods, edges never coincide with pll_clk edges.
  initial begin
    ext_clk = 1'b0;
    #23;
    forever begin
      ext_clk = ~ext_clk;
      #50;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic smp();
    @(posedge pll_clk);
    #4;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 ext source, 1 draining, 2 quiet gap, 3 pll source
  int m_mode, m_from_ext, m_gap, m_rst_edges;
  int m_div[NCH];
  int m_pos[NCH];
  bit m_ack[NCH];
  bit m_frz[NCH];
  bit m_out[NCH];
  bit m_eq[$];
  bit m_sq[$];
  bit es, ss, all_frz, trig, ld, rq;
  int n, hi;

  always @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      m_mode = 0; m_from_ext = 0; m_gap = 0; m_rst_edges = 0;
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = DINI; m_pos[i] = 0; m_ack[i] = 0; m_frz[i] = 0; m_out[i] = 0;
      end
      m_eq.delete();
      m_sq.delete();
      for (int s = 0; s < SYNC; s++) begin
        m_eq.push_back(1'b0);
        m_sq.push_back(1'b1);
      end
    end else begin
      es = m_eq[$];
      ss = m_sq[$];
      all_frz = 1'b1;
      for (int i = 0; i < NCH; i++) if (!m_frz[i]) all_frz = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        n    = (m_div[i] < 2) ? 2 : m_div[i];
        hi   = (n + 1) / 2;
        rq   = div_req[i];
        trig = rq && !m_ack[i];
        ld   = 1'b0;
        case (m_mode)
          0: begin m_out[i] = es; m_pos[i] = 0; m_frz[i] = 0; ld = trig; end
          1: begin
            ld = trig;
            if (m_frz[i]) m_out[i] = 0;
            else if (m_from_ext != 0) begin
              m_out[i] = es;
              if (!es) m_frz[i] = 1;
            end else if (m_pos[i] < hi) begin
              m_out[i] = 1;
              m_pos[i] = (m_pos[i] + 1) % n;
            end else begin
              m_out[i] = 0;
              m_frz[i] = 1;
            end
          end
          2: begin m_out[i] = 0; m_pos[i] = 0; m_frz[i] = 0; ld = trig; end
          default: begin
            m_out[i] = (m_pos[i] < hi);
            ld       = trig && (m_pos[i] == n - 1);
            m_pos[i] = (m_pos[i] == n - 1) ? 0 : m_pos[i] + 1;
            m_frz[i] = 0;
          end
        endcase
        if (ld) begin
          m_div[i] = int'(div_n[i*DIVW +: DIVW]);
          m_ack[i] = 1;
        end else if (!rq) begin
          m_ack[i] = 0;
        end
      end
      case (m_mode)
        0: if (!ss) begin m_mode = 1; m_from_ext = 1; end
        1: if (all_frz) begin m_mode = 2; m_gap = 0; end
        2: if (m_gap == 1) m_mode = (m_from_ext != 0) ? 3 : 0; else m_gap++;
        default: if (ss) begin m_mode = 1; m_from_ext = 0; end
      endcase
      m_eq.push_front(ext_clk);
      void'(m_eq.pop_back());
      m_sq.push_front(ext_clk_sel);
      void'(m_sq.pop_back());
      if (m_rst_edges < RSTS) m_rst_edges++;
    end
  end

  logic [NCH-1:0] e_clk, e_ack;

  always @(posedge pll_clk) begin
    #4;
    for (int i = 0; i < NCH; i++) begin
      e_clk[i] = m_out[i];
      e_ack[i] = m_ack[i];
    end
    chk("model_clk_out",     32'(clk_out),     32'(e_clk));
    chk("model_div_ack",     32'(div_ack),     32'(e_ack));
    chk("model_src_pll",     32'(src_pll),     32'(m_mode == 3));
    chk("model_switching",   32'(switching),   32'(m_mode == 1 || m_mode == 2));
    chk("model_resetb_sync", 32'(resetb_sync), 32'(m_rst_edges >= RSTS && !ext_reset));
  end

  // ---------------- directed scenarios ----------------
  task automatic load_div(input int ch, input int val);
    logic seen;
    @(negedge pll_clk);
    div_n[ch*DIVW +: DIVW] = DIVW'(val);
    div_req[ch] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      smp();
      seen = div_ack[ch];
    end
    chk($sformatf("ack_rise_ch%0d", ch), 32'(seen), 32'd1);
    @(negedge pll_clk);
    div_req[ch] = 1'b0;
    seen = 1'b1;
    for (int k = 0; k < 8 && seen; k++) begin
      smp();
      seen = div_ack[ch];
    end
    chk($sformatf("ack_fall_ch%0d", ch), 32'(seen), 32'd0);
  endtask

  task automatic wait_pll(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      smp();
      got = src_pll;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin
    int lat;
    logic got, seen_sw, prev, prev_sw, done;
    logic [NCH-1:0] low, rearm;

    resetb = 1'b0; ext_clk_sel = 1'b1; ext_reset = 1'b0;
    div_n = {4'd2, 4'd2}; div_req = '0;

    repeat (3) smp();
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_div_ack", 32'(div_ack), 32'd0);
    chk("rst_src_pll", 32'(src_pll), 32'd0);
    chk("rst_switching", 32'(switching), 32'd0);
    chk("rst_resetb_sync", 32'(resetb_sync), 32'd0);

    @(negedge pll_clk); resetb = 1'b1;
    smp(); chk("rst_rel_edge1", 32'(resetb_sync), 32'd0);
    smp(); chk("rst_rel_edge2", 32'(resetb_sync), 32'd0);
    smp(); chk("rst_rel_edge3", 32'(resetb_sync), 32'd1);

    @(negedge pll_clk); ext_reset = 1'b1;
    #1 chk("ext_reset_on", 32'(resetb_sync), 32'd0);
    repeat (3) @(negedge pll_clk);
    ext_reset = 1'b0;
    #1 chk("ext_reset_off", 32'(resetb_sync), 32'd1);

    // EXT latency from a pad rising edge
    @(posedge ext_clk);
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      smp();
      if (clk_out[0] && lat == 0) lat = k;
    end
    chk("ext_latency", 32'(lat), 32'(SYNC + 1));

    load_div(0, 5);
    load_div(1, 2);

    // EXT -> PLL
    @(negedge pll_clk); ext_clk_sel = 1'b0;
    seen_sw = 1'b0; got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      smp();
      if (switching) seen_sw = 1'b1;
      got = src_pll;
    end
    chk("enter_pll", 32'(got), 32'd1);
    chk("e2p_saw_switching", 32'(seen_sw), 32'd1);
    chk("pll_entry_out", 32'(clk_out), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      smp();
      chk($sformatf("n5_ch0_s%0d", k), 32'(clk_out[0]), 32'(k <= 3 || k == 6));
      chk($sformatf("n2_ch1_s%0d", k), 32'(clk_out[1]), 32'(k % 2));
    end

    // N=0 behaves as N=2
    load_div(1, 0);
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      smp();
      got = clk_out[1];
    end
    chk("n0_find_high", 32'(got), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      smp();
      chk($sformatf("n0_ch1_s%0d", k), 32'(clk_out[1]), 32'(k % 2 == 0));
    end

    // Handshake: request N=6 at count 1 of an N=4 period
    load_div(0, 4);
    got = 1'b0; prev = clk_out[0];
    for (int k = 0; k < 20 && !got; k++) begin
      smp();
      got = !prev && clk_out[0];
      prev = clk_out[0];
    end
    chk("hs_find_rise", 32'(got), 32'd1);
    @(negedge pll_clk);
    div_n[0 +: DIVW] = 4'd6; div_req[0] = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      smp();
      chk($sformatf("hs_ack_s%0d", s), 32'(div_ack[0]), 32'(s >= 3));
      chk($sformatf("hs_clk_s%0d", s), 32'(clk_out[0]), 32'(s == 1 || (s >= 4 && s <= 6) || s == 10));
    end
    @(negedge pll_clk); div_req[0] = 1'b0;
    smp(); chk("hs_ack_fall", 32'(div_ack[0]), 32'd0);

    // PLL -> EXT: no channel may rise again once frozen low
    load_div(0, 3);
    load_div(1, 4);
    @(negedge pll_clk); ext_clk_sel = 1'b1;
    seen_sw = 1'b0; done = 1'b0; prev_sw = 1'b0; low = '0; rearm = '0;
    for (int k = 0; k < 100 && !done; k++) begin
      smp();
      if (switching) seen_sw = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (switching && prev_sw && !clk_out[i]) low[i] = 1'b1;
        else if (switching && clk_out[i] && low[i]) rearm[i] = 1'b1;
      end
      if (seen_sw && !switching) done = 1'b1;
      prev_sw = switching;
    end
    chk("p2e_done", 32'(done), 32'd1);
    chk("p2e_frozen_both", 32'(low), 32'h3);
    chk("p2e_no_runt", 32'(rearm), 32'd0);
    chk("p2e_src_pll", 32'(src_pll), 32'd0);
    repeat (15) smp();

    // Reset during a drain with a request pending
    @(negedge pll_clk); ext_clk_sel = 1'b0;
    wait_pll("reenter_pll");
    @(negedge pll_clk);
    div_n[0 +: DIVW] = 4'd7; div_req[0] = 1'b1; ext_clk_sel = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      smp();
      got = switching;
    end
    chk("mid_drain_reach", 32'(got), 32'd1);
    @(negedge pll_clk); resetb = 1'b0;
    #1;
    chk("mid_rst_src_pll", 32'(src_pll), 32'd0);
    chk("mid_rst_switching", 32'(switching), 32'd0);
    chk("mid_rst_div_ack", 32'(div_ack), 32'd0);
    chk("mid_rst_clk_out", 32'(clk_out), 32'd0);
    chk("mid_rst_resetb_sync", 32'(resetb_sync), 32'd0);
    div_req = '0; ext_clk_sel = 1'b0;
    repeat (2) @(negedge pll_clk);
    resetb = 1'b1;
    wait_pll("post_rst_pll");
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk($sformatf("post_rst_div_s%0d", k), 32'(clk_out), (k % 2 == 1) ? 32'h3 : 32'h0);
    end

    repeat (5) smp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
